// File: rtl/csr_trap_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : csr_trap_ctrl
// Purpose  : Owns the CSR file port; sequences machine-mode trap entry and
//            MRET through it, otherwise passes core CSR writes straight on.
// Revision : 1.0 - initial release
// ============================================================================
module csr_trap_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        exc_valid,
    input  logic [3:0]  exc_cause,
    input  logic [31:0] exc_pc,
    input  logic        irq_ext,
    input  logic [31:0] cur_pc,
    input  logic        mstatus_mie,
    input  logic        mie_meie,
    input  logic        mret_valid,
    input  logic        core_csr_we,
    input  logic [11:0] core_csr_addr,
    input  logic [31:0] core_csr_wdata,
    output logic        csr_we,
    output logic [11:0] csr_addr,
    output logic [31:0] csr_wdata,
    input  logic [31:0] csr_rdata,
    output logic        stall,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [31:0] ALIGN_MASK  = 32'hFFFF_FFFC;
    localparam logic [31:0] IRQ_CAUSE   = 32'h8000_000B;

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        W_EPC   = 4'd1,
        W_CAUSE = 4'd2,
        R_STAT  = 4'd3,
        W_STAT  = 4'd4,
        R_TVEC  = 4'd5,
        M_RSTAT = 4'd6,
        M_WSTAT = 4'd7,
        M_REPC  = 4'd8,
        REDIR   = 4'd9
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] cause_q, cause_d;
    logic [31:0] stat_q, stat_d;
    logic [31:0] target_q, target_d;
    logic        is_irq_q, is_irq_d;

    logic        irq_pending;
    logic [31:0] trap_stat;
    logic [31:0] mret_stat;
    logic [31:0] tvec_base;

    assign irq_pending = irq_ext & mstatus_mie & mie_meie;
    assign tvec_base   = csr_rdata & ALIGN_MASK;

    // Trap entry: MPIE <- MIE, MIE <- 0, MPP <- M.  MRET: MIE <- MPIE, MPIE <- 1.
    always_comb begin
        trap_stat        = stat_q;
        trap_stat[7]     = stat_q[3];
        trap_stat[3]     = 1'b0;
        trap_stat[12:11] = 2'b11;
        mret_stat        = stat_q;
        mret_stat[3]     = stat_q[7];
        mret_stat[7]     = 1'b1;
    end

    always_comb begin
        state_d        = state_q;
        epc_d          = epc_q;
        cause_d        = cause_q;
        stat_d         = stat_q;
        target_d       = target_q;
        is_irq_d       = is_irq_q;
        stall          = 1'b1;
        csr_we         = 1'b0;
        csr_addr       = core_csr_addr;
        csr_wdata      = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;

        case (state_q)
            IDLE: begin
                stall = 1'b0;
                if (exc_valid) begin
                    epc_d    = exc_pc & ALIGN_MASK;
                    cause_d  = {28'b0, exc_cause};
                    is_irq_d = 1'b0;
                    state_d  = W_EPC;
                    stall    = 1'b1;
                end else if (irq_pending) begin
                    epc_d    = cur_pc & ALIGN_MASK;
                    cause_d  = IRQ_CAUSE;
                    is_irq_d = 1'b1;
                    state_d  = W_EPC;
                    stall    = 1'b1;
                end else if (mret_valid) begin
                    state_d  = M_RSTAT;
                    stall    = 1'b1;
                end else begin
                    csr_we    = core_csr_we;
                    csr_wdata = core_csr_wdata;
                end
            end
            W_EPC: begin
                csr_we    = 1'b1;
                csr_addr  = CSR_MEPC;
                csr_wdata = epc_q;
                state_d   = W_CAUSE;
            end
            W_CAUSE: begin
                csr_we    = 1'b1;
                csr_addr  = CSR_MCAUSE;
                csr_wdata = cause_q;
                state_d   = R_STAT;
            end
            R_STAT: begin
                csr_addr = CSR_MSTATUS;
                stat_d   = csr_rdata;
                state_d  = W_STAT;
            end
            W_STAT: begin
                csr_we    = 1'b1;
                csr_addr  = CSR_MSTATUS;
                csr_wdata = trap_stat;
                state_d   = R_TVEC;
            end
            R_TVEC: begin
                csr_addr = CSR_MTVEC;
                // Vectored mode only applies to interrupts; exceptions use the base.
                if (csr_rdata[1:0] == 2'b01 && is_irq_q) begin
                    target_d = tvec_base + {26'b0, cause_q[3:0], 2'b00};
                end else begin
                    target_d = tvec_base;
                end
                state_d = REDIR;
            end
            M_RSTAT: begin
                csr_addr = CSR_MSTATUS;
                stat_d   = csr_rdata;
                state_d  = M_WSTAT;
            end
            M_WSTAT: begin
                csr_we    = 1'b1;
                csr_addr  = CSR_MSTATUS;
                csr_wdata = mret_stat;
                state_d   = M_REPC;
            end
            M_REPC: begin
                csr_addr = CSR_MEPC;
                target_d = csr_rdata & ALIGN_MASK;
                state_d  = REDIR;
            end
            REDIR: begin
                redirect_valid = 1'b1;
                redirect_pc    = target_q;
                state_d        = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are gated while reset is held so an aborted write never lands.
        if (!rst) begin
            state_d        = IDLE;
            epc_d          = 32'h0;
            cause_d        = 32'h0;
            stat_d         = 32'h0;
            target_d       = 32'h0;
            is_irq_d       = 1'b0;
            stall          = 1'b0;
            csr_we         = 1'b0;
            csr_addr       = core_csr_addr;
            csr_wdata      = 32'h0;
            redirect_valid = 1'b0;
            redirect_pc    = 32'h0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            epc_q    <= 32'h0;
            cause_q  <= 32'h0;
            stat_q   <= 32'h0;
            target_q <= 32'h0;
            is_irq_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            epc_q    <= epc_d;
            cause_q  <= cause_d;
            stat_q   <= stat_d;
            target_q <= target_d;
            is_irq_q <= is_irq_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_csr_trap_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_csr_trap_ctrl
// Purpose  : Self-checking bench for csr_trap_ctrl with a behavioural CSR file.
// Revision : 1.0 - initial release
// ============================================================================
module tb_csr_trap_ctrl;

    logic        clk;
    logic        rst;
    logic        exc_valid;
    logic [3:0]  exc_cause;
    logic [31:0] exc_pc;
    logic        irq_ext;
    logic [31:0] cur_pc;
    logic        mstatus_mie;
    logic        mie_meie;
    logic        mret_valid;
    logic        core_csr_we;
    logic [11:0] core_csr_addr;
    logic [31:0] core_csr_wdata;
    logic        csr_we;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    csr_trap_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .exc_valid      (exc_valid),
        .exc_cause      (exc_cause),
        .exc_pc         (exc_pc),
        .irq_ext        (irq_ext),
        .cur_pc         (cur_pc),
        .mstatus_mie    (mstatus_mie),
        .mie_meie       (mie_meie),
        .mret_valid     (mret_valid),
        .core_csr_we    (core_csr_we),
        .core_csr_addr  (core_csr_addr),
        .core_csr_wdata (core_csr_wdata),
        .csr_we         (csr_we),
        .csr_addr       (csr_addr),
        .csr_wdata      (csr_wdata),
        .csr_rdata      (csr_rdata),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural CSR file; bench preloads it through the ld_* side port.
    logic [31:0] m_status, m_epc, m_cause, m_tvec;
    logic        ld_en;
    logic [11:0] ld_addr;
    logic [31:0] ld_data;

    always @(posedge clk) begin
        if (csr_we) begin
            case (csr_addr)
                12'h300: m_status <= csr_wdata;
                12'h305: m_tvec   <= csr_wdata;
                12'h341: m_epc    <= csr_wdata;
                12'h342: m_cause  <= csr_wdata;
                default: ;
            endcase
        end else if (ld_en) begin
            case (ld_addr)
                12'h300: m_status <= ld_data;
                12'h305: m_tvec   <= ld_data;
                12'h341: m_epc    <= ld_data;
                12'h342: m_cause  <= ld_data;
                default: ;
            endcase
        end
    end

    always_comb begin
        case (csr_addr)
            12'h300: csr_rdata = m_status;
            12'h305: csr_rdata = m_tvec;
            12'h341: csr_rdata = m_epc;
            12'h342: csr_rdata = m_cause;
            default: csr_rdata = 32'h0;
        endcase
    end

    typedef struct {
        int          kind;      // 0 exception, 1 interrupt, 2 mret
        logic [3:0]  cause;
        logic [31:0] pc_in;
        logic [31:0] mtvec;
        logic [31:0] mstatus;
        logic [31:0] mepc;
        logic [31:0] exp_epc;
        logic [31:0] exp_cause;
        logic [31:0] exp_stat;
        logic [31:0] exp_pc;
        int          exp_lat;
    } vec_t;

    typedef struct {
        logic [11:0] a;
        logic [31:0] d;
    } wr_t;

    typedef struct {
        logic [31:0] pc;
        int          lat;
    } rd_t;

    wr_t  exp_wr[$];
    rd_t  exp_rd[$];
    vec_t vecs[7];

    int total;
    int bad;
    int cyc;
    int start_cyc;
    int stall_cnt;
    int stall_base;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // One clock: sample outputs at the falling edge against the scoreboard,
    // then advance to just after the next rising edge.
    task automatic step();
        wr_t w;
        rd_t r;
        @(negedge clk);
        if (stall) stall_cnt++;
        if (csr_we) begin
            if (exp_wr.size() == 0) begin
                chk("unexpected_write_addr", {20'h0, csr_addr}, 32'hFFFF_FFFF);
            end else begin
                w = exp_wr.pop_front();
                chk("write_addr", {20'h0, csr_addr}, {20'h0, w.a});
                chk("write_data", csr_wdata, w.d);
            end
        end
        if (redirect_valid) begin
            if (exp_rd.size() == 0) begin
                chk("unexpected_redirect", redirect_pc, 32'hFFFF_FFFF);
            end else begin
                r = exp_rd.pop_front();
                chk("redirect_pc", redirect_pc, r.pc);
                chk("redirect_latency", cyc - start_cyc, r.lat);
            end
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic load(input logic [11:0] a, input logic [31:0] d);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        step();
        ld_en   = 1'b0;
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && (exp_wr.size() != 0 || exp_rd.size() != 0); i++) step();
        chk("drain_pending", exp_wr.size() + exp_rd.size(), 0);
    endtask

    task automatic setup_vec(input vec_t v);
        load(12'h305, v.mtvec);
        load(12'h300, v.mstatus);
        load(12'h341, v.mepc);
        stall_base = stall_cnt;
        if (v.kind != 2) begin
            exp_wr.push_back('{12'h341, v.exp_epc});
            exp_wr.push_back('{12'h342, v.exp_cause});
        end
        exp_wr.push_back('{12'h300, v.exp_stat});
        exp_rd.push_back('{v.exp_pc, v.exp_lat});
    endtask

    task automatic clear_events();
        exc_valid   = 1'b0;
        irq_ext     = 1'b0;
        mret_valid  = 1'b0;
        core_csr_we = 1'b0;
    endtask

    task automatic finish_vec(input vec_t v);
        drain(20);
        chk("stall_cycles", stall_cnt - stall_base, v.exp_lat + 1);
        chk("mstatus_after", m_status, v.exp_stat);
        chk("mepc_after", m_epc, v.exp_epc);
        if (v.kind != 2) chk("mcause_after", m_cause, v.exp_cause);
        step();
        chk("idle_stall", {31'h0, stall}, 32'h0);
    endtask

    initial begin
        vecs[0] = '{0, 4'h2, 32'h0000_0100, 32'h0000_0200, 32'h0000_0008, 32'h0,
                    32'h0000_0100, 32'h0000_0002, 32'h0000_1880, 32'h0000_0200, 6};
        vecs[1] = '{1, 4'h0, 32'h0000_0044, 32'h0000_0301, 32'h0000_0008, 32'h0,
                    32'h0000_0044, 32'h8000_000B, 32'h0000_1880, 32'h0000_032C, 6};
        vecs[2] = '{2, 4'h0, 32'h0, 32'h0, 32'h0000_1880, 32'h0000_0104,
                    32'h0000_0104, 32'h0, 32'h0000_1888, 32'h0000_0104, 4};
        vecs[3] = '{0, 4'hF, 32'h0000_1237, 32'h0000_0401, 32'h0000_0000, 32'h0,
                    32'h0000_1234, 32'h0000_000F, 32'h0000_1800, 32'h0000_0400, 6};
        vecs[4] = '{1, 4'h0, 32'h8000_0002, 32'h0000_0203, 32'hFFFF_FFFF, 32'h0,
                    32'h8000_0000, 32'h8000_000B, 32'hFFFF_FFF7, 32'h0000_0200, 6};
        vecs[5] = '{2, 4'h0, 32'h0, 32'h0, 32'h0000_0008, 32'h0000_2003,
                    32'h0000_2003, 32'h0, 32'h0000_0080, 32'h0000_2000, 4};
        vecs[6] = '{1, 4'h0, 32'h0000_0010, 32'h0000_1001, 32'h0000_0080, 32'h0,
                    32'h0000_0010, 32'h8000_000B, 32'h0000_1800, 32'h0000_102C, 6};

        total = 0; bad = 0; cyc = 0; start_cyc = 0; stall_cnt = 0; stall_base = 0;
        ld_en = 1'b0; ld_addr = 12'h0; ld_data = 32'h0;
        exc_cause = 4'h0; exc_pc = 32'h0; cur_pc = 32'h0;
        mstatus_mie = 1'b0; mie_meie = 1'b0;
        clear_events();
        core_csr_addr = 12'h0; core_csr_wdata = 32'h0;
        rst = 1'b1;
        #2 rst = 1'b0;

        // Reset: outputs quiet, address follows core, events ignored.
        exc_valid = 1'b1; core_csr_we = 1'b1;
        core_csr_addr = 12'h123; core_csr_wdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        chk("rst_stall", {31'h0, stall}, 32'h0);
        chk("rst_csr_we", {31'h0, csr_we}, 32'h0);
        chk("rst_csr_wdata", csr_wdata, 32'h0);
        chk("rst_csr_addr", {20'h0, csr_addr}, 32'h123);
        chk("rst_redirect_valid", {31'h0, redirect_valid}, 32'h0);
        chk("rst_redirect_pc", redirect_pc, 32'h0);
        step();
        clear_events();
        rst = 1'b1;
        step();

        // Table-driven trap and MRET sequences.
        for (int i = 0; i < 7; i++) begin
            setup_vec(vecs[i]);
            case (vecs[i].kind)
                0: begin exc_valid = 1'b1; exc_cause = vecs[i].cause; exc_pc = vecs[i].pc_in; end
                1: begin irq_ext = 1'b1; mstatus_mie = 1'b1; mie_meie = 1'b1; cur_pc = vecs[i].pc_in; end
                default: mret_valid = 1'b1;
            endcase
            start_cyc = cyc;
            #1;
            chk("start_stall", {31'h0, stall}, 32'h1);
            step();
            clear_events();
            finish_vec(vecs[i]);
        end

        // All events at once: exception wins, core write suppressed, late events ignored.
        setup_vec(vecs[0]);
        exc_valid = 1'b1; exc_cause = 4'h2; exc_pc = 32'h100;
        irq_ext = 1'b1; mstatus_mie = 1'b1; mie_meie = 1'b1; cur_pc = 32'h44;
        mret_valid = 1'b1;
        core_csr_we = 1'b1; core_csr_addr = 12'h305; core_csr_wdata = 32'h999;
        start_cyc = cyc;
        #1;
        chk("prio_stall", {31'h0, stall}, 32'h1);
        chk("prio_core_we_blocked", {31'h0, csr_we}, 32'h0);
        step();
        clear_events();
        step();
        exc_valid = 1'b1; mret_valid = 1'b1; irq_ext = 1'b1;
        step();
        clear_events();
        finish_vec(vecs[0]);
        chk("prio_mtvec_kept", m_tvec, 32'h200);
        for (int i = 0; i < 3; i++) step();

        // Interrupt masked: core write passes through, no trap.
        irq_ext = 1'b1; mstatus_mie = 1'b0; mie_meie = 1'b1;
        core_csr_we = 1'b1; core_csr_addr = 12'h305; core_csr_wdata = 32'h400;
        exp_wr.push_back('{12'h305, 32'h400});
        #1;
        chk("masked_stall", {31'h0, stall}, 32'h0);
        step();
        core_csr_we = 1'b0;
        mstatus_mie = 1'b1; mie_meie = 1'b0;
        #1;
        chk("meie_masked_stall", {31'h0, stall}, 32'h0);
        step();
        clear_events();
        for (int i = 0; i < 3; i++) step();
        chk("masked_mtvec", m_tvec, 32'h400);
        drain(1);

        // Reset during W_STAT: abort without writing mstatus or redirecting.
        load(12'h305, 32'h200);
        load(12'h300, 32'h8);
        exp_wr.push_back('{12'h341, 32'h100});
        exp_wr.push_back('{12'h342, 32'h2});
        exc_valid = 1'b1; exc_cause = 4'h2; exc_pc = 32'h100;
        start_cyc = cyc;
        step();
        clear_events();
        for (int i = 0; i < 3; i++) step();
        rst = 1'b0;
        #1;
        chk("abort_csr_we", {31'h0, csr_we}, 32'h0);
        chk("abort_stall", {31'h0, stall}, 32'h0);
        step();
        rst = 1'b1;
        for (int i = 0; i < 8; i++) step();
        chk("abort_idle_stall", {31'h0, stall}, 32'h0);
        chk("abort_mstatus", m_status, 32'h8);
        drain(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
